gsim_sweep_ctrl: RTL and testbench
==================================

Name: gsim_sweep_ctrl

Overview:
- Sequencer for the 16-unknown Gauss-Seidel datapath: the x/b register file plus the 2-stage compute unit.
- Counts the 16 b-load beats, then issues one row per cycle for a fixed number of sweeps.
- Generates the neighbour-zeroing masks and delayed write-back strobes, and flags the final sweep's results as valid output.
- Replaces the ad-hoc counters in the top level with one FSM.

Parameters:
N, 16, unknowns per sweep (power of two); ROW_W = log2(N)
SWEEPS, 50, sweeps executed before results are valid (1..63)
PIPE_LAT, 1, cycles from row issue to its x_new on the datapath output (1..3)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low (0 = reset)
in_en  input  1  b_in beat strobe from testbench side
abort  input  1  synchronous abort of load/run
b_shift  output  1  register-file b load/shift enable (= in_en accepted in IDLE/LOAD)
row_valid  output  1  row issued to compute unit this cycle
row_idx  output  ROW_W  row being issued
nb_mask  output  6  per-operand zero force, 1 = drive operand to 0
wb_en  output  1  write x_new into x[wb_row]
wb_row  output  ROW_W  write-back row
sweep_cnt  output  6  current issue sweep, 0-based
out_valid  output  1  x_new is a final result
out_row  output  ROW_W  row index of final result
busy  output  1  state != IDLE
done  output  1  one-cycle pulse after last result
load_err  output  1  sticky: in_en seen while RUN/FLUSH

Behaviour:
- Reset (reset=0, async): state IDLE; all counters 0; every output 0; pipeline delay line cleared.
- States: IDLE, LOAD, RUN, FLUSH.
- IDLE:
  - in_en=1 -> b_shift=1, load_cnt=1, go to LOAD, clear load_err.
  - With N=1, go straight to RUN instead.
- LOAD:
  - Each in_en=1 cycle: b_shift=1, load_cnt++. Gaps (in_en=0) hold the count.
  - When the N-th beat is accepted -> RUN on the next edge.
  - First row_valid is exactly 1 cycle after the N-th beat.
- RUN:
  - row_valid=1 every cycle; row_idx runs 0..N-1, then wraps to 0 with sweep_cnt++.
  - No stalls; the datapath forwards the freshly computed x[i-1].
  - After issuing row N-1 of sweep SWEEPS-1 -> FLUSH; sweep_cnt holds SWEEPS-1.
- nb_mask, combinational from row_idx, forced 0 when row_valid=0:
  - bit0 (x[i+1]): row=N-1
  - bit1 (x[i-1]): row=0
  - bit2 (x[i+2]): row>=N-2
  - bit3 (x[i-2]): row<=1
  - bit4 (x[i+3]): row>=N-3
  - bit5 (x[i-3]): row<=2
- Write-back delay line, PIPE_LAT deep, carries {valid, row, last_sweep}:
  - wb_en / wb_row are row_valid / row_idx delayed by PIPE_LAT.
  - out_valid = wb_en & last_sweep; out_row = wb_row.
  - Exactly N out_valid pulses, rows 0..N-1, on consecutive cycles.
- FLUSH:
  - row_valid=0; stays PIPE_LAT cycles while the delay line drains.
  - The cycle after the final wb_en: done=1 for 1 cycle, state -> IDLE.
- Timing: if the first row issues at cycle T, done is at T + SWEEPS*N + PIPE_LAT.
- in_en during RUN/FLUSH: ignored (no b_shift); sets load_err.
- in_en on the same cycle done pulses: accepted as beat 1 of a new load, since state is already IDLE on that edge.
- abort=1 in LOAD/RUN/FLUSH: next cycle state IDLE, all counters 0, delay line cleared. No further wb_en/out_valid/done.
- abort in IDLE: no effect.
- abort has priority over in_en in the same cycle.
- Async reset mid-run: immediately equivalent to abort, plus load_err cleared.
- Counters wrap-free: sweep_cnt never exceeds SWEEPS-1; load_cnt never exceeds N.

Test Plan:
- N=16, SWEEPS=2, PIPE_LAT=1; 16 consecutive in_en -> 16 b_shift pulses; first row_valid 1 cycle after beat 16 with row_idx=0 and nb_mask=6'b101010; done 33 cycles later.
- Same config, in_en gaps (8 beats, 5 idle, 8 beats) -> RUN entered only after the 16th beat; b_shift count is 16.
- Run to completion -> out_valid on 16 consecutive cycles, out_row 0..15, aligned with wb_en of sweep 1; none during sweep 0. Row 15 mask = 6'b010101; row 13 mask = 6'b010000.
- abort asserted at sweep 0, row 7 -> next cycle busy=0, wb_en=0, row_valid=0; no done pulse; a new 16-beat load then runs normally.
- in_en pulsed during RUN -> load_err=1 and held; b_shift stays 0; results unaffected. load_err clears on the next IDLE->LOAD.
- reset driven low mid-FLUSH -> all outputs 0 asynchronously, before the next clk edge.
- PIPE_LAT=3 -> wb_row trails row_idx by 3 cycles; FLUSH lasts 3 cycles; done at T+SWEEPS*16+3.

Source files
------------

// File: rtl/gsim_sweep_ctrl_if.sv
// Handshake and status bundle between the Gauss-Seidel sweep sequencer and its
// datapath/testbench side. The master drives the load strobe and abort.
interface gsim_sweep_ctrl_if #(
  parameter int unsigned ROW_W = 4
);
  logic             in_en;
  logic             abort;
  logic             b_shift;
  logic             row_valid;
  logic [ROW_W-1:0] row_idx;
  logic [5:0]       nb_mask;
  logic             wb_en;
  logic [ROW_W-1:0] wb_row;
  logic [5:0]       sweep_cnt;
  logic             out_valid;
  logic [ROW_W-1:0] out_row;
  logic             busy;
  logic             done;
  logic             load_err;

  modport master (
    output in_en, abort,
    input  b_shift, row_valid, row_idx, nb_mask, wb_en, wb_row,
           sweep_cnt, out_valid, out_row, busy, done, load_err
  );

  modport slave (
    input  in_en, abort,
    output b_shift, row_valid, row_idx, nb_mask, wb_en, wb_row,
           sweep_cnt, out_valid, out_row, busy, done, load_err
  );
endinterface

// File: rtl/gsim_sweep_ctrl.sv
// Sequencer for the N-unknown Gauss-Seidel datapath: counts b-load beats, issues
// one row per cycle for SWEEPS sweeps, and drives masks and delayed write-back.
module gsim_sweep_ctrl #(
  parameter int unsigned N        = 16,
  parameter int unsigned SWEEPS   = 50,
  parameter int unsigned PIPE_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  gsim_sweep_ctrl_if.slave bus
);

  localparam int unsigned ROW_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LCNT_W = $clog2(N + 1);
  localparam int unsigned SWP_W  = 6;
  localparam int unsigned FL_W   = 2;
  localparam int          NS     = N;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FLUSH
  } state_e;

  state_e            state_q, state_d;
  logic [LCNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [SWP_W-1:0]  sweep_q, sweep_d;
  logic [FL_W-1:0]   flush_q, flush_d;
  logic              row_valid_q, row_valid_d;
  logic              done_q, done_d;
  logic              load_err_q, load_err_d;
  logic              busy_q;
  logic              dl_clear;
  logic              b_shift_c;
  logic              last_sweep;
  logic [5:0]        nb_mask_c;
  int                row_i;

  // Write-back delay line: entry PIPE_LAT-1 is the oldest (currently retiring) row.
  logic [PIPE_LAT-1:0]            dl_valid_q, dl_last_q;
  logic [PIPE_LAT-1:0][ROW_W-1:0] dl_row_q;
  logic [PIPE_LAT:0]              dl_valid_in, dl_last_in;
  logic [PIPE_LAT:0][ROW_W-1:0]   dl_row_in;

  assign last_sweep  = (sweep_q == SWP_W'(SWEEPS - 1));
  assign dl_valid_in = {dl_valid_q, row_valid_q};
  assign dl_last_in  = {dl_last_q, row_valid_q & last_sweep};
  assign dl_row_in   = {dl_row_q, row_q};

  // Next-state, counter and strobe logic.
  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    row_d       = row_q;
    sweep_d     = sweep_q;
    flush_d     = flush_q;
    row_valid_d = 1'b0;
    done_d      = 1'b0;
    load_err_d  = load_err_q;
    dl_clear    = 1'b0;
    b_shift_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort has no meaning here, so a beat is always accepted
        if (bus.in_en) begin
          b_shift_c  = 1'b1;
          load_err_d = 1'b0;
          if (N == 1) begin
            state_d     = S_RUN;
            row_valid_d = 1'b1;
            row_d       = '0;
            sweep_d     = '0;
          end else begin
            state_d    = S_LOAD;
            load_cnt_d = LCNT_W'(1);
          end
        end
      end

      S_LOAD: begin
        if (bus.abort) begin
          state_d    = S_IDLE;
          load_cnt_d = '0;
          row_d      = '0;
          sweep_d    = '0;
          flush_d    = '0;
          dl_clear   = 1'b1;
        end else if (bus.in_en) begin
          b_shift_c = 1'b1;
          if (load_cnt_q == LCNT_W'(N - 1)) begin
            state_d     = S_RUN;
            load_cnt_d  = '0;
            row_valid_d = 1'b1;
            row_d       = '0;
            sweep_d     = '0;
          end else begin
            load_cnt_d = load_cnt_q + LCNT_W'(1);
          end
        end
      end

      S_RUN: begin
        if (bus.abort) begin
          state_d    = S_IDLE;
          load_cnt_d = '0;
          row_d      = '0;
          sweep_d    = '0;
          flush_d    = '0;
          dl_clear   = 1'b1;
        end else begin
          load_err_d = load_err_q | bus.in_en;
          if (row_q == ROW_W'(N - 1)) begin
            row_d = '0;
            if (last_sweep) begin
              state_d = S_FLUSH;
              flush_d = '0;
            end else begin
              sweep_d     = sweep_q + SWP_W'(1);
              row_valid_d = 1'b1;
            end
          end else begin
            row_d       = row_q + ROW_W'(1);
            row_valid_d = 1'b1;
          end
        end
      end

      S_FLUSH: begin
        if (bus.abort) begin
          state_d    = S_IDLE;
          load_cnt_d = '0;
          row_d      = '0;
          sweep_d    = '0;
          flush_d    = '0;
          dl_clear   = 1'b1;
        end else begin
          load_err_d = load_err_q | bus.in_en;
          if (flush_q == FL_W'(PIPE_LAT - 1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            sweep_d = '0;
            flush_d = '0;
          end else begin
            flush_d = flush_q + FL_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Neighbour-zeroing masks for operands that fall outside 0..N-1.
  always_comb begin
    nb_mask_c = '0;
    row_i     = 32'(row_q);
    if (row_valid_q) begin
      nb_mask_c[0] = (row_i == NS - 1);
      nb_mask_c[1] = (row_i == 0);
      nb_mask_c[2] = (row_i >= NS - 2);
      nb_mask_c[3] = (row_i <= 1);
      nb_mask_c[4] = (row_i >= NS - 3);
      nb_mask_c[5] = (row_i <= 2);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      load_cnt_q  <= '0;
      row_q       <= '0;
      sweep_q     <= '0;
      flush_q     <= '0;
      row_valid_q <= 1'b0;
      done_q      <= 1'b0;
      load_err_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      row_q       <= row_d;
      sweep_q     <= sweep_d;
      flush_q     <= flush_d;
      row_valid_q <= row_valid_d;
      done_q      <= done_d;
      load_err_q  <= load_err_d;
      busy_q      <= (state_d != S_IDLE);
    end
  end

  // Delay line tracks each issued row until its x_new reaches the datapath output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dl_valid_q <= '0;
      dl_last_q  <= '0;
      dl_row_q   <= '0;
    end else if (dl_clear) begin
      dl_valid_q <= '0;
      dl_last_q  <= '0;
      dl_row_q   <= '0;
    end else begin
      dl_valid_q <= dl_valid_in[PIPE_LAT-1:0];
      dl_last_q  <= dl_last_in[PIPE_LAT-1:0];
      dl_row_q   <= dl_row_in[PIPE_LAT-1:0];
    end
  end

  assign bus.b_shift   = b_shift_c;
  assign bus.row_valid = row_valid_q;
  assign bus.row_idx   = row_q;
  assign bus.nb_mask   = nb_mask_c;
  assign bus.wb_en     = dl_valid_q[PIPE_LAT-1];
  assign bus.wb_row    = dl_row_q[PIPE_LAT-1];
  assign bus.sweep_cnt = sweep_q;
  assign bus.out_valid = dl_valid_q[PIPE_LAT-1] & dl_last_q[PIPE_LAT-1];
  assign bus.out_row   = dl_row_q[PIPE_LAT-1];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_gsim_sweep_ctrl.sv
// Bench for gsim_sweep_ctrl: two instances (PIPE_LAT 1 and 3) share stimulus and
// are checked every cycle against a cycle-count based schedule model.
module tb_gsim_sweep_ctrl;

  localparam int NR  = 16;
  localparam int SWP = 2;
  localparam int SN  = NR * SWP;
  localparam int PL_A [2] = '{1, 3};

  logic clk;
  logic reset;
  logic in_en;
  logic abort;

  gsim_sweep_ctrl_if #(.ROW_W(4)) if0 ();
  gsim_sweep_ctrl_if #(.ROW_W(4)) if1 ();

  assign if0.in_en = in_en;
  assign if0.abort = abort;
  assign if1.in_en = in_en;
  assign if1.abort = abort;

  gsim_sweep_ctrl #(.N(16), .SWEEPS(2), .PIPE_LAT(1)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  gsim_sweep_ctrl #(.N(16), .SWEEPS(2), .PIPE_LAT(3)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // model state: phase 0 idle, 1 loading, 2 issuing/draining (t0 = first row cycle)
  int   phase [2];
  int   beats [2];
  int   t0 [2];
  logic lerr [2];
  logic done_p [2];
  int   bs_cnt [2];
  int   ov_cnt [2];
  int   done_cnt [2];

  task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL dut%0d %s cycle %0d: got %0d expected %0d", d, nm, cyc, act, exp);
  endtask

  function automatic logic [5:0] exp_mask(input int r);
    logic [5:0] m;
    m[0] = (r == NR - 1);
    m[1] = (r == 0);
    m[2] = (r >= NR - 2);
    m[3] = (r <= 1);
    m[4] = (r >= NR - 3);
    m[5] = (r <= 2);
    return m;
  endfunction

  task automatic model_check(input int d, input logic bs, input logic rv, input logic [3:0] ri,
                             input logic [5:0] nm, input logic we, input logic [3:0] wr,
                             input logic [5:0] sc, input logic ov, input logic [3:0] orow,
                             input logic bz, input logic dn, input logic le);
    int k, pl, e_row, e_wbrow, e_sw;
    logic e_rv, e_wb, e_ov, e_bs;
    pl = PL_A[d];
    k = 0; e_rv = 0; e_wb = 0; e_ov = 0; e_row = 0; e_wbrow = 0; e_sw = 0;
    if (phase[d] == 2) begin
      k     = cyc - t0[d];
      e_rv  = (k < SN);
      e_row = k % NR;
      e_sw  = (k < SN) ? k / NR : SWP - 1;
      e_wb  = (k >= pl);
      if (e_wb) begin
        e_wbrow = (k - pl) % NR;
        e_ov    = ((k - pl) / NR == SWP - 1);
      end
    end
    e_bs = in_en && (phase[d] == 0 || (phase[d] == 1 && !abort));
    chk(d, "b_shift", 32'(bs), 32'(e_bs));
    chk(d, "row_valid", 32'(rv), 32'(e_rv));
    chk(d, "nb_mask", 32'(nm), e_rv ? 32'(exp_mask(e_row)) : 32'(0));
    chk(d, "wb_en", 32'(we), 32'(e_wb));
    chk(d, "out_valid", 32'(ov), 32'(e_ov));
    chk(d, "busy", 32'(bz), 32'(phase[d] != 0));
    chk(d, "done", 32'(dn), 32'(done_p[d]));
    chk(d, "load_err", 32'(le), 32'(lerr[d]));
    if (e_rv) begin
      chk(d, "row_idx", 32'(ri), 32'(e_row));
      chk(d, "sweep_cnt", 32'(sc), 32'(e_sw));
    end
    if (e_wb) chk(d, "wb_row", 32'(wr), 32'(e_wbrow));
    if (e_ov) chk(d, "out_row", 32'(orow), 32'(e_wbrow));
  endtask

  task automatic model_step(input int d);
    done_p[d] = 1'b0;
    case (phase[d])
      0: if (in_en) begin
        lerr[d]  = 1'b0;
        beats[d] = 1;
        phase[d] = 1;
      end
      1: if (abort) begin
        phase[d] = 0;
        beats[d] = 0;
      end else if (in_en) begin
        beats[d]++;
        if (beats[d] == NR) begin
          phase[d] = 2;
          t0[d]    = cyc + 1;
        end
      end
      default: if (abort) begin
        phase[d] = 0;
      end else begin
        if (in_en) lerr[d] = 1'b1;
        if (cyc - t0[d] == SN + PL_A[d] - 1) begin
          phase[d]  = 0;
          done_p[d] = 1'b1;
        end
      end
    endcase
  endtask

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        phase[d] = 0; beats[d] = 0; lerr[d] = 1'b0; done_p[d] = 1'b0;
      end
    end else begin
      model_check(0, if0.b_shift, if0.row_valid, if0.row_idx, if0.nb_mask, if0.wb_en, if0.wb_row,
                  if0.sweep_cnt, if0.out_valid, if0.out_row, if0.busy, if0.done, if0.load_err);
      model_check(1, if1.b_shift, if1.row_valid, if1.row_idx, if1.nb_mask, if1.wb_en, if1.wb_row,
                  if1.sweep_cnt, if1.out_valid, if1.out_row, if1.busy, if1.done, if1.load_err);
      bs_cnt[0]   += 32'(if0.b_shift);
      bs_cnt[1]   += 32'(if1.b_shift);
      ov_cnt[0]   += 32'(if0.out_valid);
      ov_cnt[1]   += 32'(if1.out_valid);
      done_cnt[0] += 32'(if0.done);
      done_cnt[1] += 32'(if1.done);
      model_step(0);
      model_step(1);
    end
    cyc++;
  end

  task automatic drive(input logic e, input logic a);
    in_en = e;
    abort = a;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!if0.busy && !if1.busy) break;
      drive(1'b0, 1'b0);
    end
    chk(0, "idle_timeout", 32'(if0.busy | if1.busy), 32'(0));
  endtask

  int bs0, ov0, ov1, dn0, d0, d1;
  logic found;

  initial begin
    reset = 1'b0;
    in_en = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk(0, "rst_busy", 32'(if0.busy), 32'(0));
    chk(0, "rst_row_valid", 32'(if0.row_valid), 32'(0));
    chk(1, "rst_done", 32'(if1.done), 32'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;

    // consecutive load and full run, with first-row and done latency pins
    bs0 = bs_cnt[0];
    repeat (16) drive(1'b1, 1'b0);
    chk(0, "first_row_valid", 32'(if0.row_valid), 32'(1));
    chk(0, "first_row_idx", 32'(if0.row_idx), 32'(0));
    chk(0, "row0_mask", 32'(if0.nb_mask), 32'(6'b101010));
    chk(0, "b_shift_count", 32'(bs_cnt[0] - bs0), 32'(16));
    ov0 = ov_cnt[0]; ov1 = ov_cnt[1]; d0 = -1; d1 = -1;
    for (int c = 0; c < 60; c++) begin
      if (c == 13) chk(0, "row13_mask", 32'(if0.nb_mask), 32'(6'b010000));
      if (c == 15) chk(0, "row15_mask", 32'(if0.nb_mask), 32'(6'b010101));
      if (if0.done && d0 < 0) d0 = c;
      if (if1.done && d1 < 0) d1 = c;
      drive(1'b0, 1'b0);
    end
    chk(0, "done_latency", 32'(d0), 32'(33));
    chk(1, "done_latency", 32'(d1), 32'(35));
    chk(0, "out_valid_count", 32'(ov_cnt[0] - ov0), 32'(16));
    chk(1, "out_valid_count", 32'(ov_cnt[1] - ov1), 32'(16));

    // gapped load
    bs0 = bs_cnt[0];
    repeat (8) drive(1'b1, 1'b0);
    repeat (5) drive(1'b0, 1'b0);
    repeat (7) drive(1'b1, 1'b0);
    chk(0, "gap_still_loading", 32'(if0.row_valid), 32'(0));
    chk(0, "gap_busy", 32'(if0.busy), 32'(1));
    drive(1'b1, 1'b0);
    chk(0, "gap_run_start", 32'(if0.row_valid), 32'(1));
    chk(0, "gap_b_shift_count", 32'(bs_cnt[0] - bs0), 32'(16));
    wait_idle(100);

    // abort at sweep 0 row 7
    repeat (16) drive(1'b1, 1'b0);
    repeat (7) drive(1'b0, 1'b0);
    chk(0, "abort_row", 32'(if0.row_idx), 32'(7));
    drive(1'b0, 1'b1);
    chk(0, "abort_busy", 32'(if0.busy), 32'(0));
    chk(0, "abort_wb_en", 32'(if0.wb_en), 32'(0));
    chk(1, "abort_wb_en", 32'(if1.wb_en), 32'(0));
    chk(1, "abort_row_valid", 32'(if1.row_valid), 32'(0));
    dn0 = done_cnt[0];
    repeat (40) drive(1'b0, 1'b0);
    chk(0, "abort_no_done", 32'(done_cnt[0] - dn0), 32'(0));
    ov0 = ov_cnt[0];
    repeat (16) drive(1'b1, 1'b0);
    wait_idle(100);
    chk(0, "post_abort_results", 32'(ov_cnt[0] - ov0), 32'(16));

    // in_en during RUN
    repeat (16) drive(1'b1, 1'b0);
    bs0 = bs_cnt[0]; ov1 = ov_cnt[1];
    repeat (5) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    chk(0, "load_err_set", 32'(if0.load_err), 32'(1));
    chk(1, "load_err_set", 32'(if1.load_err), 32'(1));
    wait_idle(100);
    chk(0, "run_no_b_shift", 32'(bs_cnt[0] - bs0), 32'(0));
    chk(0, "load_err_held", 32'(if0.load_err), 32'(1));
    chk(1, "results_unaffected", 32'(ov_cnt[1] - ov1), 32'(16));
    drive(1'b1, 1'b0);
    chk(0, "load_err_cleared", 32'(if0.load_err), 32'(0));
    repeat (15) drive(1'b1, 1'b0);
    wait_idle(100);

    // async reset mid-FLUSH
    repeat (16) drive(1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (if1.busy && !if1.row_valid) begin
        found = 1'b1;
        break;
      end
      drive(1'b0, 1'b0);
    end
    chk(1, "flush_reached", 32'(found), 32'(1));
    #2;
    reset = 1'b0;
    #1;
    chk(1, "arst_busy", 32'(if1.busy), 32'(0));
    chk(1, "arst_wb_en", 32'(if1.wb_en), 32'(0));
    chk(1, "arst_wb_row", 32'(if1.wb_row), 32'(0));
    chk(1, "arst_sweep_cnt", 32'(if1.sweep_cnt), 32'(0));
    chk(1, "arst_load_err", 32'(if1.load_err), 32'(0));
    chk(0, "arst_done", 32'(if0.done), 32'(0));
    chk(0, "arst_out_valid", 32'(if0.out_valid), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // randomized traffic with occasional aborts
    for (int i = 0; i < 2500; i++) begin
      drive(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 149) == 0));
    end
    wait_idle(100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
